gmii_tx_arbiter: RTL and testbench
==================================

Name: gmii_tx_arbiter

Overview:
- Shares the single GMII transmit path between two frame sources: requester 0 (FM/IQ sample streamer) and requester 1 (ARP/ICMP reply generator).
- Grants one source at a time and forwards its byte stream to gmii_txd/gmii_tx_en with one register stage.
- Enforces the inter-frame gap, a first-byte timeout and a maximum-frame-length truncation.
- Sits between the MAC-layer frame builders and the GMII-to-RGMII converter, in the gmii_tx_clk domain.

Parameters:
- IFG_CYCLES, 12, minimum idle cycles on gmii_tx_en between frames.
- MAX_LEN, 1530, maximum bytes forwarded per frame (preamble+SFD+frame+FCS); further bytes are dropped.
- START_TO, 16, cycles a granted source may wait before its first valid byte.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, requester 0 wins.

Ports:
- clk  input  1  transmit clock (gmii_tx_clk, 125 MHz).
- rst_n  input  1  asynchronous active-low reset.
- req0, req1  input  1 each  level request from each source.
- gnt0, gnt1  output  1 each  grant; at most one is high at any time.
- valid0, valid1  input  1 each  byte valid from each source; the frame ends when valid falls.
- data0, data1  input  8 each  frame bytes from each source.
- gmii_txd  output  8  data to the GMII/RGMII converter.
- gmii_tx_en  output  1  transmit enable.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  one-cycle pulse when a start timeout occurs.
- oversize_err  output  1  one-cycle pulse when a frame is truncated.
- frame_cnt0, frame_cnt1  output  16 each  count of completed or truncated frames per source; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs = 0.
  - byte_cnt = 0, ifg_cnt = 0, to_cnt = 0.
  - last_owner = 1, so requester 0 wins the first tie.
- State IDLE:
  - If no request is high, stay in IDLE.
  - If one request is high, grant that source.
  - If both are high: with PRIO_MODE=0, grant the source that is not last_owner; with PRIO_MODE=1, grant source 0.
  - On the next edge, gnt_w=1, owner is latched, to_cnt=0, state -> GRANT.
- State GRANT:
  - gnt_w stays high; req inputs are ignored from here until the grant ends.
  - If valid_w=1 is sampled: next cycle gmii_tx_en=1, gmii_txd=data_w, byte_cnt=1, state -> XMIT.
  - Otherwise to_cnt increments.
  - If to_cnt reaches START_TO-1 with no valid: gnt_w=0, timeout_err pulses, last_owner=owner, state -> IDLE. No IFG applies because nothing was sent.
- State XMIT:
  - Latency is exactly one cycle: each sampled valid byte appears on gmii_txd the following cycle.
  - If valid_w=1 and byte_cnt < MAX_LEN: forward the byte, byte_cnt increments.
  - If valid_w=0: gmii_tx_en=0 and gnt_w=0 next cycle, frame_cnt_w increments, state -> IFG.
  - If valid_w=1 and byte_cnt == MAX_LEN: truncate. Same actions as the valid_w=0 case, plus oversize_err pulses.
  - After truncation, the source must drop valid once gnt falls; remaining bytes are ignored.
  - On either exit, last_owner = owner.
- State IFG:
  - gmii_tx_en=0 and gmii_txd=0.
  - ifg_cnt counts up to IFG_CYCLES, then the state returns to IDLE.
  - Requests arriving during IFG are held (level) and are arbitrated in IDLE.
- Guaranteed gap: gmii_tx_en is low for at least IFG_CYCLES+2 cycles between frames (IFG count, IDLE decision, one-cycle GRANT).
- gmii_txd is 0 whenever gmii_tx_en is 0.
- Simultaneous events:
  - A request from the current owner arriving as its frame ends is treated as a new request after IFG.
  - Round-robin then favours the other source if both are requesting.
- Reset mid-frame: gmii_tx_en drops immediately (asynchronously) and all state clears. The truncated frame is not counted.

Test Plan:
- Single frame: req0=1, valid0 high for 64 bytes (0x55×7, 0xD5, 0x00..0x37) -> gnt0 rises one cycle after req0. gmii_tx_en is high for exactly 64 cycles, with bytes identical to the input delayed one cycle. frame_cnt0=1, gmii_tx_en low ≥14 cycles after the frame.
- Round-robin: PRIO_MODE=0, req0=req1=1 continuously, 60-byte frames from each -> grants alternate 0,1,0,1. frame_cnt0 = frame_cnt1 after 10 frames, never two gnt high at once.
- Fixed priority: PRIO_MODE=1, both requesting continuously -> only source 0 is granted, frame_cnt1 stays 0.
- Start timeout: req1=1, valid1 held low -> gnt1 falls after 16 cycles, timeout_err pulses once, gmii_tx_en never rises. A pending req0 is then granted.
- Oversize: valid0 held high for 1600 bytes -> exactly 1530 bytes forwarded, oversize_err pulses once, frame_cnt0 increments by 1.
- Reset mid-frame: rst_n=0 at byte 30 -> gmii_tx_en and gnt0 are 0 within the reset cycle, frame_cnt0 is 0 after release. Normal operation resumes on the next request.

Source files
------------

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
//   Shares one GMII transmit path between two frame sources (0: FM/IQ
//   sample streamer, 1: ARP/ICMP reply generator). One source is granted at
//   a time and its bytes are forwarded to gmii_txd/gmii_tx_en through one
//   register stage. The block enforces an inter-frame gap, a first-byte
//   timeout and truncation of frames longer than MAX_LEN.
//
// Ports
//   clk, rst_n          gmii_tx_clk, asynchronous active-low reset
//   req0/req1           level requests from each source
//   gnt0/gnt1           grants (mutually exclusive)
//   valid0/1, data0/1   byte stream per source; frame ends when valid falls
//   gmii_txd/gmii_tx_en registered GMII transmit data / enable
//   busy                high in every state except IDLE
//   timeout_err         one-cycle pulse on first-byte timeout
//   oversize_err        one-cycle pulse when a frame is truncated
//   frame_cnt0/1        completed or truncated frames per source (wrapping)
module gmii_tx_arbiter #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MAX_LEN    = 1530,
  parameter int unsigned START_TO   = 16,
  parameter int unsigned PRIO_MODE  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        valid0,
  input  logic        valid1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        busy,
  output logic        timeout_err,
  output logic        oversize_err,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1
);

  localparam int unsigned BC_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned TO_W  = $clog2(START_TO + 1);
  localparam int unsigned IFG_W = $clog2(IFG_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GRANT, XMIT, IFG} state_t;

  state_t           state;
  logic             owner;
  logic             last_owner;
  logic [BC_W-1:0]  byte_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [IFG_W-1:0] ifg_cnt;

  logic             pick;
  logic             valid_w;
  logic [7:0]       data_w;

  assign valid_w = owner ? valid1 : valid0;
  assign data_w  = owner ? data1  : data0;
  assign busy    = (state != IDLE);

  // Source chosen in IDLE; on a tie round-robin favours the source that
  // did not own the last grant, fixed priority always favours source 0.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = (PRIO_MODE == 1) ? 1'b0 : ~last_owner;
    end else begin
      pick = ~req0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      byte_cnt     <= '0;
      to_cnt       <= '0;
      ifg_cnt      <= '0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      gmii_txd     <= '0;
      gmii_tx_en   <= 1'b0;
      timeout_err  <= 1'b0;
      oversize_err <= 1'b0;
      frame_cnt0   <= '0;
      frame_cnt1   <= '0;
    end else begin
      timeout_err  <= 1'b0;
      oversize_err <= 1'b0;
      case (state)
        IDLE: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= '0;
          if (req0 || req1) begin
            owner  <= pick;
            gnt0   <= ~pick;
            gnt1   <= pick;
            to_cnt <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (valid_w) begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= data_w;
            byte_cnt   <= BC_W'(1);
            state      <= XMIT;
          end else if (to_cnt == TO_W'(START_TO - 1)) begin
            // Nothing was sent, so return straight to IDLE without a gap.
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            timeout_err <= 1'b1;
            last_owner  <= owner;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        XMIT: begin
          if (valid_w && (byte_cnt < BC_W'(MAX_LEN))) begin
            gmii_txd <= data_w;
            byte_cnt <= byte_cnt + BC_W'(1);
          end else begin
            // End of frame, or truncation when valid is still high at MAX_LEN.
            gmii_tx_en   <= 1'b0;
            gmii_txd     <= '0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            oversize_err <= valid_w;
            last_owner   <= owner;
            byte_cnt     <= '0;
            ifg_cnt      <= '0;
            if (owner) frame_cnt1 <= frame_cnt1 + 16'd1;
            else       frame_cnt0 <= frame_cnt0 + 16'd1;
            state <= IFG;
          end
        end
        IFG: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= '0;
          if (ifg_cnt == IFG_W'(IFG_CYCLES - 1)) begin
            ifg_cnt <= '0;
            state   <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + IFG_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
module tb_gmii_tx_arbiter;

  localparam int unsigned IFG  = 12;
  localparam int unsigned MAXL = 1530;
  localparam int unsigned STO  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #4 clk = ~clk;

  logic       req0, req1, valid0, valid1;
  logic [7:0] data0, data1;

  logic        a_gnt0, a_gnt1, a_en, a_busy, a_to, a_ov;
  logic [7:0]  a_txd;
  logic [15:0] a_fc0, a_fc1;
  logic        p_gnt0, p_gnt1, p_en, p_busy, p_to, p_ov;
  logic [7:0]  p_txd;
  logic [15:0] p_fc0, p_fc1;

  gmii_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_LEN(MAXL), .START_TO(STO), .PRIO_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .gnt0(a_gnt0), .gnt1(a_gnt1),
    .valid0(valid0), .valid1(valid1), .data0(data0), .data1(data1),
    .gmii_txd(a_txd), .gmii_tx_en(a_en), .busy(a_busy), .timeout_err(a_to),
    .oversize_err(a_ov), .frame_cnt0(a_fc0), .frame_cnt1(a_fc1));

  gmii_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_LEN(MAXL), .START_TO(STO), .PRIO_MODE(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .gnt0(p_gnt0), .gnt1(p_gnt1),
    .valid0(valid0), .valid1(valid1), .data0(data0), .data1(data1),
    .gmii_txd(p_txd), .gmii_tx_en(p_en), .busy(p_busy), .timeout_err(p_to),
    .oversize_err(p_ov), .frame_cnt0(p_fc0), .frame_cnt1(p_fc1));

  // Sources and checks follow whichever instance is selected.
  logic        use_p = 1'b0;
  logic        s_gnt0, s_gnt1, s_en, s_busy, s_to, s_ov;
  logic [7:0]  s_txd;
  logic [15:0] s_fc0, s_fc1;
  always_comb begin
    s_gnt0 = use_p ? p_gnt0 : a_gnt0;
    s_gnt1 = use_p ? p_gnt1 : a_gnt1;
    s_en   = use_p ? p_en   : a_en;
    s_busy = use_p ? p_busy : a_busy;
    s_to   = use_p ? p_to   : a_to;
    s_ov   = use_p ? p_ov   : a_ov;
    s_txd  = use_p ? p_txd  : a_txd;
    s_fc0  = use_p ? p_fc0  : a_fc0;
    s_fc1  = use_p ? p_fc1  : a_fc1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame bytes: 7x 0x55, 0xD5, then an incrementing payload offset by source.
  function automatic logic [7:0] byte_at(input int src, input int i);
    if (i < 7)       return 8'h55;
    else if (i == 7) return 8'hD5;
    else             return 8'((i - 8) + src * 128);
  endfunction

  // Source models: once granted, drive len bytes then drop valid; drop valid
  // as soon as the grant is gone (covers truncation and reset).
  int   len0 = 0, len1 = 0, sent0 = 0, sent1 = 0;
  logic mute0 = 1'b0, mute1 = 1'b0;

  initial begin
    valid0 = 1'b0; data0 = '0;
    forever begin
      @(posedge clk); #1;
      if (!s_gnt0) begin
        valid0 = 1'b0; data0 = '0; sent0 = 0;
      end else if (!mute0 && sent0 < len0) begin
        valid0 = 1'b1; data0 = byte_at(0, sent0); sent0++;
      end else begin
        valid0 = 1'b0; data0 = '0;
      end
    end
  end

  initial begin
    valid1 = 1'b0; data1 = '0;
    forever begin
      @(posedge clk); #1;
      if (!s_gnt1) begin
        valid1 = 1'b0; data1 = '0; sent1 = 0;
      end else if (!mute1 && sent1 < len1) begin
        valid1 = 1'b1; data1 = byte_at(1, sent1); sent1++;
      end else begin
        valid1 = 1'b0; data1 = '0;
      end
    end
  end

  // Output monitor: byte content, idle data, grant exclusivity, gap length.
  int   idx = 0, lowrun = 0, min_gap = 1000;
  logic seen = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        idx = 0; lowrun = 0; seen = 1'b0;
      end else begin
        chk("gnt_excl", 32'(s_gnt0 & s_gnt1), 0);
        if (s_en) begin
          if (idx == 0 && seen) begin
            chk("ifg_gap", 32'(lowrun >= int'(IFG + 2)), 1);
            if (lowrun < min_gap) min_gap = lowrun;
          end
          chk("txd_byte", 32'(s_txd), 32'(byte_at(s_gnt1 ? 1 : 0, idx)));
          idx++; lowrun = 0; seen = 1'b1;
        end else begin
          chk("txd_idle", 32'(s_txd), 0);
          idx = 0; lowrun++;
        end
      end
    end
  end

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      if (!s_busy) done = 1;
    end
    chk(name, 32'(done), 1);
  endtask

  typedef struct {
    bit rst; bit sel_p; bit r0; bit r1;
    int l0; int l1; bit m0; bit m1;
    int exp_src; int exp_len; bit exp_to; bit exp_ov;
  } row_t;

  task automatic run_row(input int n, input row_t r);
    int lat = 0, gc = 1, tc = 0, toc = 0, ovc = 0, src;
    bit got = 0, done = 0;
    logic [15:0] fc0_b, fc1_b, inc;
    string tag;
    tag = $sformatf("row%0d", n);
    if (r.rst) do_reset();
    use_p = r.sel_p; len0 = r.l0; len1 = r.l1; mute0 = r.m0; mute1 = r.m1;
    fc0_b = s_fc0; fc1_b = s_fc1;
    req0 = r.r0; req1 = r.r1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      if (s_gnt0 || s_gnt1) got = 1;
    end
    chk({tag, "_grant_seen"}, 32'(got), 1);
    src = s_gnt1 ? 1 : 0;
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      if (s_gnt0 || s_gnt1) gc++;
      if (s_en) tc++;
      if (s_to) toc++;
      if (s_ov) ovc++;
      if (!s_busy) done = 1;
    end
    inc = r.exp_to ? 16'd0 : 16'd1;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_latency"}, 32'(lat), 1);
    chk({tag, "_src"}, 32'(src), 32'(r.exp_src));
    chk({tag, "_len"}, 32'(tc), 32'(r.exp_len));
    chk({tag, "_gnt_cycles"}, 32'(gc), r.exp_to ? STO : 32'(r.exp_len + 1));
    chk({tag, "_timeout"}, 32'(toc), 32'(r.exp_to));
    chk({tag, "_oversize"}, 32'(ovc), 32'(r.exp_ov));
    chk({tag, "_fc0"}, 32'(s_fc0), 32'(fc0_b + (r.exp_src == 0 ? inc : 16'd0)));
    chk({tag, "_fc1"}, 32'(s_fc1), 32'(fc1_b + (r.exp_src == 1 ? inc : 16'd0)));
  endtask

  row_t rows[10];

  initial begin
    int cnt, got, src, dly;
    bit ok;
    //          rst sp r0 r1  l0    l1  m0 m1 src len  to ov
    rows[0] = '{1, 0, 1, 0,   64,   60, 0, 0, 0,  64,  0, 0};
    rows[1] = '{0, 0, 1, 1,   60,   60, 0, 0, 1,  60,  0, 0};
    rows[2] = '{0, 0, 1, 1,   60,   60, 0, 0, 0,  60,  0, 0};
    rows[3] = '{0, 0, 0, 1,   60,   60, 0, 1, 1,  0,   1, 0};
    rows[4] = '{0, 0, 1, 1,   60,   20, 0, 0, 0,  60,  0, 0};
    rows[5] = '{0, 0, 0, 1,   60,   1,  0, 0, 1,  1,   0, 0};
    rows[6] = '{0, 0, 1, 0,   1600, 60, 0, 0, 0,  1530, 0, 1};
    rows[7] = '{1, 1, 1, 1,   60,   60, 0, 0, 0,  60,  0, 0};
    rows[8] = '{0, 1, 1, 1,   60,   60, 0, 0, 0,  60,  0, 0};
    rows[9] = '{0, 1, 0, 1,   60,   45, 0, 0, 1,  45,  0, 0};

    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b0;
    #3;
    chk("reset_rr", {a_gnt0, a_gnt1, a_en, a_busy, a_to, a_ov, a_txd, a_fc0 | a_fc1}, 0);
    chk("reset_prio", {p_gnt0, p_gnt1, p_en, p_busy, p_to, p_ov, p_txd, p_fc0 | p_fc1}, 0);
    do_reset();

    for (int i = 0; i < 10; i++) run_row(i, rows[i]);

    // Round-robin with both sources requesting continuously.
    do_reset();
    use_p = 1'b0; len0 = 60; len1 = 60; mute0 = 1'b0; mute1 = 1'b0;
    min_gap = 1000;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      got = 0;
      for (int c = 0; c < 200 && got == 0; c++) begin
        @(posedge clk); #1;
        if (s_gnt0 || s_gnt1) got = 1;
      end
      src = s_gnt1 ? 1 : 0;
      chk($sformatf("rr_grant%0d_src", k), 32'(got ? src : 9), 32'(k % 2));
      if (k == 9) begin req0 = 1'b0; req1 = 1'b0; end
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(posedge clk); #1;
        if (!s_gnt0 && !s_gnt1) ok = 1;
      end
    end
    wait_idle("rr_idle");
    chk("rr_fc0", 32'(s_fc0), 5);
    chk("rr_fc1", 32'(s_fc1), 5);
    chk("rr_min_gap", 32'(min_gap), IFG + 2);

    // Fixed priority with both sources requesting continuously.
    do_reset();
    use_p = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int c = 0; c < 200 && got == 0; c++) begin
        @(posedge clk); #1;
        if (s_gnt0 || s_gnt1) got = 1;
      end
      chk($sformatf("prio_grant%0d", k), {30'd0, s_gnt1, s_gnt0}, 1);
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(posedge clk); #1;
        if (!s_gnt0 && !s_gnt1) ok = 1;
      end
    end
    wait_idle("prio_idle");
    chk("prio_fc0", 32'(s_fc0), 4);
    chk("prio_fc1", 32'(s_fc1), 0);

    // Start timeout on source 1 with a pending request from source 0.
    do_reset();
    use_p = 1'b0; mute1 = 1'b1; len0 = 64;
    req1 = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      @(posedge clk); #1;
      if (s_gnt1) got = 1;
    end
    chk("to_gnt1_seen", 32'(got), 1);
    req1 = 1'b0; req0 = 1'b1;
    cnt = 1; dly = 0; got = 0; ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(posedge clk); #1;
      if (s_en) got++;
      if (s_to) dly++;
      if (s_gnt1) cnt++;
      else ok = 1;
    end
    chk("to_gnt1_cycles", 32'(cnt), STO);
    chk("to_pulses", 32'(dly), 1);
    chk("to_no_tx", 32'(got), 0);
    dly = 0; ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(posedge clk); #1;
      dly++;
      if (s_gnt0) ok = 1;
      if (s_to) got++;
    end
    chk("to_pending_gnt0_delay", ok ? 32'(dly) : 99, 1);
    chk("to_no_second_pulse", 32'(got), 0);
    req0 = 1'b0; mute1 = 1'b0;
    wait_idle("to_idle");
    chk("to_fc0", 32'(s_fc0), 1);
    chk("to_fc1", 32'(s_fc1), 0);

    // Reset in the middle of a frame from source 0.
    len0 = 64;
    req0 = 1'b1;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 30; c++) begin
      @(posedge clk); #1;
      if (s_en) cnt++;
      if (s_gnt0) req0 = 1'b0;
    end
    chk("rst_mid_reached", 32'(cnt), 30);
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_en", 32'(s_en), 0);
    chk("rst_mid_gnt0", 32'(s_gnt0), 0);
    chk("rst_mid_txd", 32'(s_txd), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_fc0", 32'(s_fc0), 0);
    chk("rst_mid_busy", 32'(s_busy), 0);
    run_row(10, rows[0]);
    chk("rst_resume_fc0", 32'(s_fc0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
